bist_host: RTL and testbench

- Initiator and checker on the far side of the BIST controller handshake.
- On a software/top-level request it issues a `bist_start` rising edge to the controller.
- It then monitors the controller's `init`/`mode`/`running`/`finish`/`bist_end` outputs, checks them against the expected protocol and burst geometry, and reports pass/fail plus observed counts.
- Sits between the test-access/top-level logic and the BIST controller.

---
 rtl/bist_host.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bist_host.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_host.sv
// bist_host: initiator and protocol checker facing a BIST controller.
// On an accepted request it pulses bist_start for one cycle, then follows the controller's
// init/mode/running/finish/bist_end outputs, checking the handshake order and the burst
// geometry (EXP_BURSTS bursts of EXP_LEN mode cycles). It reports one done pulse per run
// with a sticky pass flag, the first error code seen, and the observed burst count/length.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   req         start request, only sampled while idle
//   init, mode, running, finish, bist_end   controller status inputs
//   bist_start  one-cycle start strobe to the controller
//   busy        high from request accept until done
//   done        one-cycle completion pulse
//   pass        sticky result, valid with done, cleared on the next accept
//   err_code    0 none, 1 init timeout, 2 init length, 3 burst length, 4 burst count,
//               5 illegal encoding, 6 run watchdog
//   bursts_obs  bursts counted in the current/last run
//   len_obs     length of the most recent completed burst
module bist_host #(
   parameter int unsigned EXP_LEN      = 7,
   parameter int unsigned EXP_BURSTS   = 11,
   parameter int unsigned INIT_TIMEOUT = 4,
   parameter int unsigned RUN_TIMEOUT  = 1023,
   parameter int unsigned CW           = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req,
   input  logic          init,
   input  logic          mode,
   input  logic          running,
   input  logic          finish,
   input  logic          bist_end,
   output logic          bist_start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [2:0]    err_code,
   output logic [CW-1:0] bursts_obs,
   output logic [CW-1:0] len_obs
);

   localparam int unsigned TW = $clog2(INIT_TIMEOUT + 1);
   localparam int unsigned WW = $clog2(RUN_TIMEOUT + 1);

   localparam logic [2:0] ErrNone     = 3'd0;
   localparam logic [2:0] ErrInitTmo  = 3'd1;
   localparam logic [2:0] ErrInitLen  = 3'd2;
   localparam logic [2:0] ErrBurstLen = 3'd3;
   localparam logic [2:0] ErrBurstCnt = 3'd4;
   localparam logic [2:0] ErrIllegal  = 3'd5;
   localparam logic [2:0] ErrWatchdog = 3'd6;

   // {init, mode, running, finish, bist_end}
   localparam logic [4:0] EncNone = 5'b00000;
   localparam logic [4:0] EncInit = 5'b10000;
   localparam logic [4:0] EncMr   = 5'b01100;
   localparam logic [4:0] EncRun  = 5'b00100;
   localparam logic [4:0] EncFin  = 5'b00010;
   localparam logic [4:0] EncEnd  = 5'b00001;

   typedef enum logic [3:0] {
      StIdle, StStart, StWaitInit, StInit, StBurst, StGap, StFinish, StDone, StError
   } state_e;

   state_e          state_q, state_d;
   logic            bist_start_q, bist_start_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [2:0]      err_code_q, err_code_d;
   logic [CW-1:0]   bursts_obs_q, bursts_obs_d;
   logic [CW-1:0]   len_obs_q, len_obs_d;
   logic [CW-1:0]   len_q, len_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [WW-1:0]   wd_q, wd_d;

   logic [4:0] enc;
   logic       legal;
   logic       checked;
   logic       fail;
   logic [2:0] fail_code;

   assign enc = {init, mode, running, finish, bist_end};

   always_comb begin
      legal = 1'b0;
      case (enc)
         EncNone, EncInit, EncMr, EncRun, EncFin, EncEnd: legal = 1'b1;
         default:                                          legal = 1'b0;
      endcase
   end

   assign checked = (state_q == StWaitInit) || (state_q == StInit) || (state_q == StBurst) ||
                    (state_q == StGap) || (state_q == StFinish);

   always_comb begin
      state_d      = state_q;
      bist_start_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      err_code_d   = err_code_q;
      bursts_obs_d = bursts_obs_q;
      len_obs_d    = len_obs_q;
      len_d        = len_q;
      tmo_d        = tmo_q;
      wd_d         = wd_q;
      fail         = 1'b0;
      fail_code    = ErrNone;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d      = StStart;
               bist_start_d = 1'b1;
               busy_d       = 1'b1;
               pass_d       = 1'b0;
               err_code_d   = ErrNone;
               bursts_obs_d = '0;
               len_obs_d    = '0;
            end
         end
         StStart: begin
            state_d = StWaitInit;
            tmo_d   = '0;
         end
         StWaitInit: begin
            // Anything other than init (including a stale bist_end) just waits.
            if (init) begin
               state_d = StInit;
               wd_d    = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(INIT_TIMEOUT)) begin
                  fail      = 1'b1;
                  fail_code = ErrInitTmo;
               end
            end
         end
         StInit: begin
            wd_d = wd_q + WW'(1);
            if (enc == EncMr) begin
               state_d = StBurst;
               len_d   = CW'(1);
            end else begin
               fail      = 1'b1;
               fail_code = ErrInitLen;
            end
         end
         StBurst: begin
            wd_d = wd_q + WW'(1);
            if (enc == EncMr) begin
               if (len_q != '1) len_d = len_q + CW'(1);
            end else if (enc == EncRun) begin
               len_obs_d = len_q;
               if (bursts_obs_q != '1) bursts_obs_d = bursts_obs_q + CW'(1);
               if (len_q != CW'(EXP_LEN)) begin
                  fail      = 1'b1;
                  fail_code = ErrBurstLen;
               end else begin
                  state_d = StGap;
               end
            end else begin
               fail      = 1'b1;
               fail_code = ErrIllegal;
            end
         end
         StGap: begin
            wd_d = wd_q + WW'(1);
            if (enc == EncMr) begin
               state_d = StBurst;
               len_d   = CW'(1);
            end else if (enc == EncFin) begin
               if (bursts_obs_q != CW'(EXP_BURSTS)) begin
                  fail      = 1'b1;
                  fail_code = ErrBurstCnt;
               end else begin
                  state_d = StFinish;
               end
            end else begin
               fail      = 1'b1;
               fail_code = ErrIllegal;
            end
         end
         StFinish: begin
            if (enc == EncEnd) begin
               state_d = StDone;
               pass_d  = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               fail      = 1'b1;
               fail_code = ErrIllegal;
            end
         end
         StDone, StError: state_d = StIdle;
         default:         state_d = StIdle;
      endcase

      // Watchdog only fires while the run would otherwise still be in progress.
      if (!fail && ((state_d == StBurst) || (state_d == StGap)) &&
          (wd_d >= WW'(RUN_TIMEOUT))) begin
         fail      = 1'b1;
         fail_code = ErrWatchdog;
      end

      // Illegal encodings outrank every other check in the same cycle.
      if (checked && !legal) begin
         fail      = 1'b1;
         fail_code = ErrIllegal;
      end

      if (fail) begin
         state_d    = StError;
         err_code_d = fail_code;
         pass_d     = 1'b0;
         done_d     = 1'b1;
         busy_d     = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         bist_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_code_q   <= ErrNone;
         bursts_obs_q <= '0;
         len_obs_q    <= '0;
         len_q        <= '0;
         tmo_q        <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         bist_start_q <= bist_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_code_q   <= err_code_d;
         bursts_obs_q <= bursts_obs_d;
         len_obs_q    <= len_obs_d;
         len_q        <= len_d;
         tmo_q        <= tmo_d;
         wd_q         <= wd_d;
      end
   end

   assign bist_start = bist_start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_code   = err_code_q;
   assign bursts_obs = bursts_obs_q;
   assign len_obs    = len_obs_q;

endmodule

// File: tb/tb_bist_host.sv
// Bench for bist_host: a behavioural controller plays a per-cycle sequence of status
// encodings; a run-length parser of the same sequence predicts the verdict.
module tb_bist_host;

   localparam int unsigned EXP_LEN      = 7;
   localparam int unsigned EXP_BURSTS   = 11;
   localparam int unsigned INIT_TIMEOUT = 4;
   localparam int unsigned RUN_TIMEOUT  = 1023;
   localparam int unsigned CW           = 8;
   localparam int          SAT          = (1 << CW) - 1;

   // {init, mode, running, finish, bist_end}
   localparam logic [4:0] E_NONE = 5'b00000;
   localparam logic [4:0] E_INIT = 5'b10000;
   localparam logic [4:0] E_MR   = 5'b01100;
   localparam logic [4:0] E_R    = 5'b00100;
   localparam logic [4:0] E_F    = 5'b00010;
   localparam logic [4:0] E_E    = 5'b00001;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req = 1'b0;
   logic          init = 1'b0, mode = 1'b0, running = 1'b0, finish = 1'b0, bist_end = 1'b0;
   logic          bist_start, busy, done, pass;
   logic [2:0]    err_code;
   logic [CW-1:0] bursts_obs, len_obs;

   int n_cmp = 0;
   int n_bad = 0;

   logic [4:0] seq[$];
   int         blen[16];

   bist_host #(
      .EXP_LEN(EXP_LEN), .EXP_BURSTS(EXP_BURSTS), .INIT_TIMEOUT(INIT_TIMEOUT),
      .RUN_TIMEOUT(RUN_TIMEOUT), .CW(CW)
   ) dut (
      .clock(clock), .reset(reset), .req(req),
      .init(init), .mode(mode), .running(running), .finish(finish), .bist_end(bist_end),
      .bist_start(bist_start), .busy(busy), .done(done), .pass(pass),
      .err_code(err_code), .bursts_obs(bursts_obs), .len_obs(len_obs)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] e);
      {init, mode, running, finish, bist_end} = e;
   endtask

   function automatic logic [4:0] at(input int i);
      return (i < seq.size()) ? seq[i] : E_NONE;
   endfunction

   function automatic bit legal(input logic [4:0] e);
      return e inside {E_NONE, E_INIT, E_MR, E_R, E_F, E_E};
   endfunction

   // Parses the sample sequence (index 0 = first sample after the start strobe) and
   // returns the verdict and the index of the sample that decides it.
   function automatic void model(output int code, output int k, output int nb, output int ln);
      int i, init_at, n;
      logic [4:0] e;
      code = 0; k = 0; nb = 0; ln = 0;
      i = 0;
      forever begin
         e = at(i);
         if (!legal(e)) begin code = 5; k = i; return; end
         if (e == E_INIT) break;
         if (i + 1 >= int'(INIT_TIMEOUT)) begin code = 1; k = i; return; end
         i++;
      end
      init_at = i;
      i++;
      e = at(i);
      if (!legal(e)) begin code = 5; k = i; return; end
      if (e != E_MR) begin code = 2; k = i; return; end
      n = 1;
      i++;
      forever begin
         e = at(i);
         if (!legal(e)) begin code = 5; k = i; return; end
         if (e == E_MR) begin
            if (i - init_at >= int'(RUN_TIMEOUT)) begin code = 6; k = i; return; end
            if (n < SAT) n++;
            i++;
            continue;
         end
         if (e != E_R) begin code = 5; k = i; return; end
         if (nb < SAT) nb++;
         ln = n;
         if (n != int'(EXP_LEN)) begin code = 3; k = i; return; end
         if (i - init_at >= int'(RUN_TIMEOUT)) begin code = 6; k = i; return; end
         i++;
         e = at(i);
         if (!legal(e)) begin code = 5; k = i; return; end
         if (e == E_F) begin
            if (nb != int'(EXP_BURSTS)) begin code = 4; k = i; return; end
            i++;
            code = (at(i) == E_E) ? 0 : 5;
            k = i;
            return;
         end
         if (e != E_MR) begin code = 5; k = i; return; end
         if (i - init_at >= int'(RUN_TIMEOUT)) begin code = 6; k = i; return; end
         n = 1;
         i++;
      end
   endfunction

   task automatic default_lens();
      for (int b = 0; b < 16; b++) blen[b] = EXP_LEN;
   endtask

   task automatic build(input int pre, input int nb, input bit stale);
      seq.delete();
      repeat (pre) seq.push_back(stale ? E_E : E_NONE);
      seq.push_back(E_INIT);
      for (int b = 0; b < nb; b++) begin
         repeat (blen[b]) seq.push_back(E_MR);
         seq.push_back(E_R);
      end
      seq.push_back(E_F);
      seq.push_back(E_E);
   endtask

   task automatic do_run(input string tag, input bit hold);
      int exp_code, exp_k, exp_b, exp_l;
      int done_at, starts;
      model(exp_code, exp_k, exp_b, exp_l);
      @(negedge clock);
      req = 1'b1;
      for (int c = 0; c < 4 && !bist_start; c++) @(negedge clock);
      chk({tag, "/bist_start"}, bist_start, 1);
      chk({tag, "/busy_on"}, busy, 1);
      chk({tag, "/cleared"}, {pass, err_code, bursts_obs, len_obs}, 0);
      if (!hold) req = 1'b0;
      starts = 1;
      done_at = -1;
      for (int i = 0; i < 1300; i++) begin
         @(negedge clock);
         if (bist_start) starts++;
         if (done) begin done_at = i; break; end
         drive(at(i));
      end
      chk({tag, "/done_at"}, done_at, exp_k + 1);
      chk({tag, "/err_code"}, err_code, exp_code);
      chk({tag, "/pass"}, pass, (exp_code == 0) ? 1 : 0);
      chk({tag, "/bursts_obs"}, bursts_obs, exp_b);
      chk({tag, "/len_obs"}, len_obs, exp_l);
      chk({tag, "/busy_off"}, busy, 0);
      chk({tag, "/starts"}, starts, 1);
      // Controller holds bist_end after a good run until the next start.
      drive((exp_code == 0) ? E_E : E_NONE);
      @(negedge clock);
      chk({tag, "/done_pulse"}, done, 0);
   endtask

   initial begin
      int p, nb, idx;
      #3;
      chk("reset_outputs", {bist_start, busy, done, pass, err_code, bursts_obs, len_obs}, 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_after_reset", {bist_start, busy, done}, 0);

      default_lens();
      build(2, EXP_BURSTS, 1'b1);
      do_run("nominal", 1'b0);

      default_lens();
      blen[1] = EXP_LEN - 1;
      build(1, EXP_BURSTS, 1'b0);
      do_run("short_burst", 1'b0);

      seq.delete();
      do_run("missing_init", 1'b0);

      default_lens();
      build(0, EXP_BURSTS, 1'b0);
      seq[11] = 5'b01000;
      do_run("mode_only", 1'b0);

      build(0, EXP_BURSTS, 1'b0);
      seq[9] = 5'b10010;
      do_run("finish_init", 1'b0);

      build(0, EXP_BURSTS - 1, 1'b0);
      do_run("wrong_count", 1'b0);
      build(1, EXP_BURSTS, 1'b0);
      do_run("after_wrong_count", 1'b0);

      seq.delete();
      seq.push_back(E_INIT);
      repeat (1100) seq.push_back(E_MR);
      do_run("watchdog", 1'b0);

      // Reset in the middle of the second burst.
      build(0, EXP_BURSTS, 1'b0);
      @(negedge clock);
      req = 1'b1;
      for (int c = 0; c < 4 && !bist_start; c++) @(negedge clock);
      req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         drive(at(i));
      end
      @(negedge clock);
      chk("mid_run_bursts", bursts_obs, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset", {bist_start, busy, done, pass, err_code, bursts_obs, len_obs}, 0);
      @(negedge clock);
      drive(E_NONE);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_after_mid_reset", {bist_start, busy, done}, 0);

      // req held through a run, then a back-to-back run.
      build(1, EXP_BURSTS, 1'b0);
      do_run("held_req_a", 1'b1);
      build(2, EXP_BURSTS, 1'b1);
      do_run("held_req_b", 1'b0);

      for (int r = 0; r < 24; r++) begin
         default_lens();
         nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(EXP_BURSTS - 1, EXP_BURSTS + 1))
                                          : EXP_BURSTS;
         for (int b = 0; b < nb; b++)
            if ($urandom_range(0, 15) == 0) blen[b] = $urandom_range(1, 10);
         p = $urandom_range(0, INIT_TIMEOUT);
         build(p, nb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, seq.size() - 1);
            seq[idx] = 5'($urandom_range(0, 31));
         end
         do_run($sformatf("random%0d", r), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
